// File: rtl/duckhunt_pkg.sv
// Shared types and widths for the duck-hunt shooter/target blocks.
package duckhunt_pkg;

    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        KILL     = 2'd1,
        ESCAPE   = 2'd2,
        COOLDOWN = 2'd3
    } hs_state_t;

    localparam int COORD_W = 10;
    localparam int CNT_W   = 8;
    localparam int AMMO_W  = 4;
    localparam int COOL_W  = 8;

endpackage

// File: rtl/hit_scorer_if.sv
// Mouse/target inputs and score outputs of the hit scorer; master drives the
// mouse and box side, slave (the scorer) drives the results.
interface hit_scorer_if;
    import duckhunt_pkg::*;

    logic                mouse_btn;
    logic [31:0]         mouseX;
    logic [31:0]         mouseY;
    logic [COORD_W-1:0]  BoxX;
    logic [COORD_W-1:0]  BoxY;
    logic [COORD_W-1:0]  BoxS;
    logic                kill;
    logic                escape;
    logic [CNT_W-1:0]    hit_count;
    logic [CNT_W-1:0]    click_count;
    logic [AMMO_W-1:0]   ammo;

    modport master (
        output mouse_btn, mouseX, mouseY, BoxX, BoxY, BoxS,
        input  kill, escape, hit_count, click_count, ammo
    );

    modport slave (
        input  mouse_btn, mouseX, mouseY, BoxX, BoxY, BoxS,
        output kill, escape, hit_count, click_count, ammo
    );

endinterface

// File: rtl/box_hit_test.sv
// Combinational point-in-square test; zero latency, no backpressure.
// Edge sums are one bit wider than the coordinates so boxes near 1023 never wrap.
module box_hit_test
    import duckhunt_pkg::*;
(
    input  logic [31:0]        pos_x,
    input  logic [31:0]        pos_y,
    input  logic [COORD_W-1:0] box_x,
    input  logic [COORD_W-1:0] box_y,
    input  logic [COORD_W-1:0] box_s,
    output logic               hit
);

    logic [COORD_W:0] x_end;
    logic [COORD_W:0] y_end;
    logic             in_range;
    logic             in_x;
    logic             in_y;

    always_comb begin
        x_end    = {1'b0, box_x} + {1'b0, box_s};
        y_end    = {1'b0, box_y} + {1'b0, box_s};
        in_range = ~|pos_x[31:COORD_W] & ~|pos_y[31:COORD_W];
        in_x     = (pos_x[COORD_W-1:0] >= box_x) && ({1'b0, pos_x[COORD_W-1:0]} < x_end);
        in_y     = (pos_y[COORD_W-1:0] >= box_y) && ({1'b0, pos_y[COORD_W-1:0]} < y_end);
        hit      = in_range & in_x & in_y;
    end

endmodule

// File: rtl/hit_scorer.sv
// Scores mouse clicks against the target box; kill/escape pulse one frame after
// the click edge is registered, counts update on the same edge. No backpressure.
module hit_scorer
    import duckhunt_pkg::*;
#(
    parameter int unsigned AMMO            = 3,
    parameter int unsigned COOLDOWN_FRAMES = 30,
    parameter int unsigned MAX_HIT         = 60
) (
    input  logic        frame_clk,
    input  logic        Reset,
    hit_scorer_if.slave bus
);

    localparam logic [AMMO_W-1:0] AMMO_FULL = AMMO_W'(AMMO);
    localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(COOLDOWN_FRAMES);
    localparam logic [CNT_W-1:0]  HIT_SAT   = CNT_W'(MAX_HIT);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    hs_state_t         state;
    hs_state_t         state_n;
    logic              btn_q;
    logic              btn_q2;
    logic              click;
    logic              hit;
    logic [COOL_W-1:0] cool;
    logic [COOL_W-1:0] cool_n;
    logic [CNT_W-1:0]  hit_cnt;
    logic [CNT_W-1:0]  hit_cnt_n;
    logic [CNT_W-1:0]  click_cnt;
    logic [CNT_W-1:0]  click_cnt_n;
    logic [AMMO_W-1:0] ammo_q;
    logic [AMMO_W-1:0] ammo_n;

    box_hit_test u_box_hit_test (
        .pos_x (bus.mouseX),
        .pos_y (bus.mouseY),
        .box_x (bus.BoxX),
        .box_y (bus.BoxY),
        .box_s (bus.BoxS),
        .hit   (hit)
    );

    // Rising edge of the registered button; a held button yields one click.
    assign click = btn_q & ~btn_q2;

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state     <= ARMED;
            btn_q     <= 1'b0;
            btn_q2    <= 1'b0;
            cool      <= '0;
            hit_cnt   <= '0;
            click_cnt <= '0;
            ammo_q    <= AMMO_FULL;
        end else begin
            state     <= state_n;
            btn_q     <= bus.mouse_btn;
            btn_q2    <= btn_q;
            cool      <= cool_n;
            hit_cnt   <= hit_cnt_n;
            click_cnt <= click_cnt_n;
            ammo_q    <= ammo_n;
        end
    end

    always_comb begin
        state_n     = state;
        cool_n      = cool;
        hit_cnt_n   = hit_cnt;
        click_cnt_n = click_cnt;
        ammo_n      = ammo_q;
        case (state)
            ARMED: begin
                if (click) begin
                    if (click_cnt != CNT_MAX) click_cnt_n = click_cnt + CNT_W'(1);
                    if (hit) begin
                        if (hit_cnt < HIT_SAT) hit_cnt_n = hit_cnt + CNT_W'(1);
                        ammo_n  = AMMO_FULL;
                        state_n = KILL;
                    end else if (ammo_q > AMMO_W'(1)) begin
                        ammo_n = ammo_q - AMMO_W'(1);
                    end else begin
                        ammo_n  = AMMO_FULL;
                        state_n = ESCAPE;
                    end
                end
            end
            KILL, ESCAPE: begin
                cool_n  = COOL_LOAD;
                state_n = COOLDOWN;
            end
            COOLDOWN: begin
                // Clicks are dropped here; the button must produce a fresh edge once armed.
                cool_n = cool - COOL_W'(1);
                if (cool == COOL_W'(1)) state_n = ARMED;
            end
            default: state_n = ARMED;
        endcase
    end

    always_comb begin
        bus.kill        = (state == KILL);
        bus.escape      = (state == ESCAPE);
        bus.hit_count   = hit_cnt;
        bus.click_count = click_cnt;
        bus.ammo        = ammo_q;
    end

endmodule

// File: tb/tb_hit_scorer.sv
// Self-checking bench for hit_scorer: vector table plus hand-written sequences,
// with kill/escape pulses matched against a queue of expected events.
module tb_hit_scorer;
    import duckhunt_pkg::*;

    localparam int AMMO_T = 3;
    localparam int COOL_T = 30;
    localparam int HSAT_T = 60;

    typedef struct packed {
        logic       kill;
        logic       esc;
        logic [7:0] hit;
        logic [7:0] click;
        logic [3:0] ammo;
    } obs_t;

    typedef struct {
        logic [31:0] mx;
        logic [31:0] my;
        logic [9:0]  bx;
        logic [9:0]  by;
        logic [9:0]  bs;
        bit          hit;
        string       name;
    } vec_t;

    logic frame_clk = 1'b0;
    logic Reset     = 1'b1;

    hit_scorer_if ifc ();

    hit_scorer #(
        .AMMO            (AMMO_T),
        .COOLDOWN_FRAMES (COOL_T),
        .MAX_HIT         (HSAT_T)
    ) dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (ifc)
    );

    always #5 frame_clk = ~frame_clk;

    int   nchk = 0;
    int   nerr = 0;
    int   cyc  = 0;
    int   m_hit = 0;
    int   m_click = 0;
    int   m_ammo = AMMO_T;
    int   armed_edge = 0;
    int   kill_seen = 0;
    int   esc_seen = 0;
    bit   prev_pulse = 1'b0;
    obs_t sb_q[$];
    vec_t vecs[10];

    always @(posedge frame_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic obs_t model_obs(input logic k, input logic e);
        obs_t o;
        o.kill  = k;
        o.esc   = e;
        o.hit   = 8'(m_hit);
        o.click = 8'(m_click);
        o.ammo  = 4'(m_ammo);
        return o;
    endfunction

    function automatic logic [31:0] counts_now();
        return 32'({ifc.hit_count, ifc.click_count, ifc.ammo});
    endfunction

    function automatic logic [31:0] counts_of(input int h, input int c, input int a);
        return 32'({8'(h), 8'(c), 4'(a)});
    endfunction

    function automatic vec_t mkv(input logic [31:0] mx, input logic [31:0] my,
                                 input logic [9:0] bx, input logic [9:0] by,
                                 input logic [9:0] bs, input bit h, input string nm);
        vec_t v;
        v.mx = mx; v.my = my; v.bx = bx; v.by = by; v.bs = bs; v.hit = h; v.name = nm;
        return v;
    endfunction

    // Pulse scoreboard: every kill/escape must match the next expected event.
    always @(posedge frame_clk) begin
        obs_t e;
        #1;
        if (ifc.kill === 1'b1 || ifc.escape === 1'b1) begin
            if (ifc.kill === 1'b1) kill_seen++;
            if (ifc.escape === 1'b1) esc_seen++;
            if (sb_q.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL unexpected_pulse: kill=%0b escape=%0b, expected no pulse (cycle %0d)",
                         ifc.kill, ifc.escape, cyc);
            end else begin
                e = sb_q.pop_front();
                chk("pulse_obs", 32'({ifc.kill, ifc.escape, ifc.hit_count, ifc.click_count, ifc.ammo}),
                    32'(e));
            end
            chk("pulse_not_consecutive", 32'(prev_pulse), 32'd0);
        end
        prev_pulse = (ifc.kill === 1'b1) || (ifc.escape === 1'b1);
    end

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic wait_until(input int e);
        while (cyc < e) tick();
    endtask

    task automatic wait_armed();
        while (cyc < armed_edge - 1) tick();
    endtask

    task automatic do_reset(input int n, input string nm);
        Reset = 1'b1;
        repeat (n) tick();
        m_hit = 0;
        m_click = 0;
        m_ammo = AMMO_T;
        armed_edge = 0;
        sb_q.delete();
        chk({nm, "_pulses"}, 32'({ifc.kill, ifc.escape}), 32'd0);
        chk({nm, "_counts"}, counts_now(), counts_of(0, 0, AMMO_T));
        Reset = 1'b0;
    endtask

    // One press: button rises before edge k, held for 'hold' edges, then released.
    task automatic press(input logic [31:0] mx, input logic [31:0] my,
                         input logic [9:0] bx, input logic [9:0] by, input logic [9:0] bs,
                         input bit exp_hit, input int hold, input string nm);
        int k;
        ifc.mouseX = mx;
        ifc.mouseY = my;
        ifc.BoxX = bx;
        ifc.BoxY = by;
        ifc.BoxS = bs;
        ifc.mouse_btn = 1'b1;
        tick();
        k = cyc;
        if (k >= armed_edge) begin
            if (m_click < 255) m_click++;
            if (exp_hit) begin
                if (m_hit < HSAT_T) m_hit++;
                m_ammo = AMMO_T;
                sb_q.push_back(model_obs(1'b1, 1'b0));
                armed_edge = k + COOL_T + 2;
            end else if (m_ammo > 1) begin
                m_ammo--;
            end else begin
                m_ammo = AMMO_T;
                sb_q.push_back(model_obs(1'b0, 1'b1));
                armed_edge = k + COOL_T + 2;
            end
        end
        tick();
        chk({nm, "_counts"}, counts_now(), counts_of(m_hit, m_click, m_ammo));
        tick();
        chk({nm, "_pulse_width"}, 32'({ifc.kill, ifc.escape}), 32'd0);
        chk({nm, "_pulse_seen"}, 32'(sb_q.size()), 32'd0);
        repeat (hold - 2) tick();
        ifc.mouse_btn = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int k0;
        int n0;
        int esc_ammo[3];
        esc_ammo[0] = 2; esc_ammo[1] = 1; esc_ammo[2] = 3;

        vecs[0] = mkv(32'd163,        32'd263,        10'd100,  10'd200, 10'd64, 1'b1, "edge_far_corner");
        vecs[1] = mkv(32'd100,        32'd200,        10'd100,  10'd200, 10'd64, 1'b1, "edge_near_corner");
        vecs[2] = mkv(32'd164,        32'd230,        10'd100,  10'd200, 10'd64, 1'b0, "edge_right_out");
        vecs[3] = mkv(32'd99,         32'd230,        10'd100,  10'd200, 10'd64, 1'b0, "edge_left_out");
        vecs[4] = mkv(32'h0000_0482,  32'd230,        10'd100,  10'd200, 10'd64, 1'b0, "edge_x_upper_bits");
        vecs[5] = mkv(32'd663,        32'd230,        10'd600,  10'd200, 10'd64, 1'b1, "edge_wide_sum");
        vecs[6] = mkv(32'd130,        32'd264,        10'd100,  10'd200, 10'd64, 1'b0, "edge_bottom_out");
        vecs[7] = mkv(32'd130,        32'h0000_04E6,  10'd100,  10'd200, 10'd64, 1'b0, "edge_y_upper_bits");
        vecs[8] = mkv(32'd100,        32'd200,        10'd100,  10'd200, 10'd0,  1'b0, "edge_zero_size");
        vecs[9] = mkv(32'd1023,       32'd210,        10'd1000, 10'd200, 10'd30, 1'b1, "edge_top_of_range");

        ifc.mouse_btn = 1'b1;
        ifc.mouseX = 32'd10;
        ifc.mouseY = 32'd10;
        ifc.BoxX = 10'd100;
        ifc.BoxY = 10'd200;
        ifc.BoxS = 10'd64;

        // Reset with the button held; release yields a single (missing) click.
        do_reset(2, "rst_hold");
        repeat (5) tick();
        chk("rst_release_one_click", counts_now(), counts_of(0, 1, 2));
        ifc.mouse_btn = 1'b0;
        tick();
        do_reset(2, "rst_clean");

        // Hit, ignored presses inside cooldown, then re-arm boundary.
        press(32'd130, 32'd230, 10'd100, 10'd200, 10'd64, 1'b1, 2, "hit_first");
        repeat (5) tick();
        press(32'd130, 32'd230, 10'd100, 10'd200, 10'd64, 1'b1, 2, "hit_in_cooldown");
        e = armed_edge;
        wait_until(e - 2);
        press(32'd130, 32'd230, 10'd100, 10'd200, 10'd64, 1'b1, 2, "hit_one_early");
        wait_armed();
        press(32'd130, 32'd230, 10'd100, 10'd200, 10'd64, 1'b1, 2, "hit_after_cooldown");
        e = armed_edge;
        wait_until(e - 1);
        press(32'd130, 32'd230, 10'd100, 10'd200, 10'd64, 1'b1, 2, "hit_exact_rearm");
        chk("hit_seq_totals", counts_now(), counts_of(3, 3, 3));

        // Boundary vectors.
        do_reset(2, "rst_edges");
        for (int i = 0; i < 10; i++) begin
            wait_armed();
            press(vecs[i].mx, vecs[i].my, vecs[i].bx, vecs[i].by, vecs[i].bs,
                  vecs[i].hit, 2, vecs[i].name);
        end

        // Escape after three misses; a fourth press during cooldown is dropped.
        do_reset(2, "rst_escape");
        k0 = kill_seen;
        n0 = esc_seen;
        for (int i = 0; i < 3; i++) begin
            press(32'd10, 32'd10, 10'd100, 10'd200, 10'd64, 1'b0, 2, "esc_miss");
            chk("esc_ammo", 32'(ifc.ammo), 32'(esc_ammo[i]));
        end
        press(32'd10, 32'd10, 10'd100, 10'd200, 10'd64, 1'b0, 2, "esc_in_cooldown");
        chk("esc_totals", counts_now(), counts_of(0, 3, 3));
        chk("esc_pulse_count", 32'(esc_seen - n0), 32'd1);
        chk("esc_no_kill", 32'(kill_seen - k0), 32'd0);

        // Button held for 100 frames over the target.
        do_reset(2, "rst_held");
        k0 = kill_seen;
        press(32'd130, 32'd230, 10'd100, 10'd200, 10'd64, 1'b1, 100, "held");
        chk("held_totals", counts_now(), counts_of(1, 1, 3));
        chk("held_kill_count", 32'(kill_seen - k0), 32'd1);

        // Saturation of both counters.
        do_reset(2, "rst_sat");
        for (int i = 0; i < 70; i++) begin
            wait_armed();
            press(32'd130, 32'd230, 10'd100, 10'd200, 10'd64, 1'b1, 2, "sat_hit");
        end
        chk("sat_hit_count", 32'(ifc.hit_count), 32'd60);
        for (int i = 0; i < 240; i++) begin
            wait_armed();
            press(32'd10, 32'd10, 10'd100, 10'd200, 10'd64, 1'b0, 2, "sat_click");
        end
        chk("sat_click_count", 32'(ifc.click_count), 32'd255);
        chk("sat_hit_hold", 32'(ifc.hit_count), 32'd60);

        // Reset in the middle of cooldown, then an immediate accepted press.
        wait_armed();
        press(32'd130, 32'd230, 10'd100, 10'd200, 10'd64, 1'b1, 2, "cd_hit");
        repeat (5) tick();
        do_reset(1, "rst_cooldown");
        press(32'd130, 32'd230, 10'd100, 10'd200, 10'd64, 1'b1, 2, "after_rst_cd");
        chk("after_rst_cd_totals", counts_now(), counts_of(1, 1, 3));

        repeat (3) tick();
        chk("sb_empty_end", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/hit_scorer.md
Name: hit_scorer

Overview:
- Shooter-side counterpart of the moving target.
- Takes the mouse button and cursor position plus the target's BoxX/BoxY/BoxS each frame, and decides hit or miss.
- Produces the kill pulse, hit_count and click_count that the target block consumes.
- Also tracks ammo per target and flags an escape when all shots miss. Sits between the mouse interface and the target/score display.

Parameters:
- AMMO, 3, shots per target before escape (1..15).
- COOLDOWN_FRAMES, 30, frames in which clicks are ignored after a kill or escape (1..255).
- MAX_HIT, 60, saturation value of hit_count; bounds target speed and edge margins.

Ports:
- frame_clk  in  1  frame-rate clock, sole clock.
- Reset  in  1  synchronous, active-high reset.
- mouse_btn  in  1  left button level, raw.
- mouseX  in  32  cursor X in pixels.
- mouseY  in  32  cursor Y in pixels.
- BoxX  in  10  target left edge.
- BoxY  in  10  target top edge.
- BoxS  in  10  target side length.
- kill  out  1  one-cycle pulse on hit; target respawns.
- escape  out  1  one-cycle pulse when ammo is exhausted without a hit.
- hit_count  out  8  saturating hit total.
- click_count  out  8  saturating accepted-click total.
- ammo  out  4  shots remaining for the current target.

Behaviour:
- Clocking: single clock frame_clk. Reset is synchronous and active-high; it is sampled only on the frame_clk rising edge.
- Reset values:
  - kill=0, escape=0, hit_count=0, click_count=0.
  - ammo=AMMO, state=ARMED, cooldown counter=0.
  - Button sync registers btn_q=0, btn_q2=0.
  - Reset has priority over all other activity in every state, including mid-KILL and mid-COOLDOWN.
- Click detect:
  - btn_q<=mouse_btn; btn_q2<=btn_q; click = btn_q & ~btn_q2.
  - A held button produces exactly one click.
- Hit test (combinational, on the cycle click is high):
  - Hit requires mouseX[31:10]==0, mouseY[31:10]==0, BoxX <= mouseX[9:0] < BoxX+BoxS, and BoxY <= mouseY[9:0] < BoxY+BoxS.
  - Both sums are 11 bits, with no wrap.
  - BoxS=0 never hits.
- States:
  - ARMED:
    - On click: click_count+1 (saturates at 255).
    - Hit: hit_count+1 (saturates at MAX_HIT), ammo<=AMMO, kill<=1 → KILL.
    - Miss with ammo>1: ammo-1, stay ARMED.
    - Miss with ammo==1: ammo<=AMMO, escape<=1 → ESCAPE.
  - KILL: kill is high for this one cycle; load cooldown=COOLDOWN_FRAMES → COOLDOWN.
  - ESCAPE: escape is high for this one cycle; load cooldown → COOLDOWN.
  - COOLDOWN:
    - Decrement each cycle; at 1 → ARMED.
    - click is ignored and not counted.
    - A button held across the cooldown end does not fire, because there is no new edge.
- Latency:
  - The button is first sampled high at edge k, so click is high during cycle k..k+1.
  - Counts update and kill/escape are registered at edge k+1.
  - The pulse is high for exactly the cycle k+1..k+2.
- Output rules:
  - kill and escape are mutually exclusive, and each is never high on two consecutive cycles.
  - Counts never wrap.
  - Box inputs are not registered; the values present on the click cycle decide the result.

Decomposition:
- Package duckhunt_pkg holds:
  - enum hs_state_t {ARMED, KILL, ESCAPE, COOLDOWN};
  - COORD_W=10;
  - CNT_W=8.
- Sub-module box_hit_test: combinational rectangle compare (mouseX, mouseY, BoxX, BoxY, BoxS → hit). Reusable by any future multi-target logic.

Test Plan:
- Reset: hold Reset 2 cycles with mouse_btn=1 → kill=0, escape=0, counts=0, ammo=3. Releasing Reset with the button still held gives at most one click, only when btn_q first goes high after reset.
- Hit: Box=(100,200,S=64), mouse=(130,230), button rises at edge k → kill=1 for cycle k+1..k+2 only; hit_count=1, click_count=1, ammo=3. A second press 10 frames later is ignored (click_count stays 1). A press after 30 frames is counted.
- Edges: Box=(100,200,64):
  - (163,263) → hit.
  - (164,230) → miss.
  - (99,230) → miss.
  - mouseX=32'h0000_0482 → miss (upper bits set).
  - Box=(600,200,64), mouse=(663,230) → hit (11-bit sum, no wrap).
- Escape: three misses with separate presses → ammo counts 2,1 then returns to 3; escape pulses once on the third miss; kill stays 0; click_count=3. A fourth press during cooldown is not counted.
- Held button: mouse_btn=1 for 100 frames over the target → exactly one kill, click_count=1.
- Saturation/reset:
  - Drive 70 hits (with cooldowns) → hit_count=60.
  - Drive 300 clicks → click_count=255.
  - Assert Reset mid-COOLDOWN → next cycle state=ARMED, counts=0, and an immediate new press is accepted.
